// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline definitions: register indexing, long-op counter width and
// the forwarding-unit select encodings.
package stall_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int NREG   = 32;
    localparam int LCNT_W = 3;

    typedef logic [REG_W-1:0] regIdx_t;

    typedef enum logic [1:0] {
        FORWARD_NONE = 2'b00,
        FORWARD_WB   = 2'b01,
        FORWARD_MEM  = 2'b10
    } forward_e;

endpackage

// File: rtl/long_scoreboard.sv
// Tracks long-latency ops from issue in Execute to writeback: per-register
// pending bits, the in-flight count and a sticky protocol-error flag.
module long_scoreboard
    import stall_ctrl_pkg::*;
#(
    parameter int MAX_LONG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  regIdx_t           issueRd,
    input  logic              doneValid,
    input  regIdx_t           doneRd,
    output logic [NREG-1:0]   pending,
    output logic [LCNT_W-1:0] outstanding,
    output logic              atLimit,
    output logic              sbErr
);

    localparam logic [LCNT_W-1:0] MAX_CNT = LCNT_W'(MAX_LONG);

    logic [NREG-1:0]   pendingNxt;
    logic [LCNT_W-1:0] outstandingNxt;
    logic              errNow;

    assign atLimit = (outstanding >= MAX_CNT);

    // Clear first, then set: a same-cycle issue is the newer writer of rd.
    always_comb begin
        pendingNxt = pending;
        if (doneValid) pendingNxt[doneRd] = 1'b0;
        if (issueValid && (issueRd != '0)) pendingNxt[issueRd] = 1'b1;
        pendingNxt[0] = 1'b0;
    end

    always_comb begin
        outstandingNxt = outstanding;
        if (issueValid && !doneValid && (outstanding != MAX_CNT))
            outstandingNxt = outstanding + 1'b1;
        else if (doneValid && !issueValid && (outstanding != '0))
            outstandingNxt = outstanding - 1'b1;
    end

    assign errNow = (doneValid && (outstanding == '0))
                  || (doneValid && (doneRd != '0) && !pending[doneRd])
                  || (issueValid && (outstanding == MAX_CNT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            outstanding <= '0;
            sbErr       <= 1'b0;
        end else begin
            pending     <= pendingNxt;
            outstanding <= outstandingNxt;
            sbErr       <= sbErr | errNow;
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Decode-side hazard controller: load-use, long-op scoreboard and structural
// stalls, branch-redirect flushes and a stall-cycle performance counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MAX_LONG = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  regIdx_t          rs1D,
    input  regIdx_t          rs2D,
    input  regIdx_t          rdD,
    input  logic             RegWriteD,
    input  logic             LongD,
    input  regIdx_t          rdE,
    input  logic             RegWriteE,
    input  logic             ResultSrcE0,
    input  logic             LongIssueE,
    input  logic             PCSrcE,
    input  logic             LongDoneW,
    input  regIdx_t          LongRdW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [NREG-1:0]  Pending,
    output logic             SbErr,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [LCNT_W-1:0] MAX_CNT = LCNT_W'(MAX_LONG);

    logic [NREG-1:0]   pending;
    logic [LCNT_W-1:0] outstanding;
    logic              atLimit;
    logic              sbErr;
    logic              lwStall, sbStall, stStall, stall, redirect;

    long_scoreboard #(.MAX_LONG(MAX_LONG)) uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .issueValid (LongIssueE),
        .issueRd    (rdE),
        .doneValid  (LongDoneW),
        .doneRd     (LongRdW),
        .pending    (pending),
        .outstanding(outstanding),
        .atLimit    (atLimit),
        .sbErr      (sbErr)
    );

    assign lwStall = ResultSrcE0 & RegWriteE & (rdE != '0)
                   & ((rdE == rs1D) | (rdE == rs2D));
    assign sbStall = pending[rs1D] | pending[rs2D] | (RegWriteD & pending[rdD]);
    // An issue leaving Execute this edge already occupies a slot.
    assign stStall = LongD & (atLimit | (LongIssueE & (outstanding == MAX_CNT - 1'b1)));

    // Outputs are held low for the whole reset window, not just registered state.
    assign redirect = PCSrcE & rst;
    assign stall    = (lwStall | sbStall | stStall) & ~PCSrcE & rst;

    assign StallF  = stall;
    assign StallD  = stall;
    assign FlushD  = redirect;
    assign FlushE  = redirect | stall;
    assign Pending = pending;
    assign SbErr   = sbErr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) StallCnt <= '0;
        else if (stall) StallCnt <= StallCnt + 1'b1;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Decode-side hazard controller for the 5-stage RISC-V pipeline. It is the stall/flush counterpart to the execute-stage forwarding unit: forwarding covers hazards that bypass can resolve, and this block holds Fetch/Decode and bubbles Execute for the rest. It covers load-use hazards, taken-branch redirects, and long-latency (MUL/DIV) results. A register scoreboard and an outstanding-op counter track in-flight long ops from issue in E to writeback in W.

## Interface
- MAX_LONG, default 2: maximum number of long ops in flight (1..7).
- CNT_W, default 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rs1D, rs2D, rdD  in  5 each  source and destination registers of the Decode instruction.
- RegWriteD, LongD  in  1 each  Decode instruction writes rd; Decode instruction is a long op.
- rdE  in  5  destination register of the Execute instruction.
- RegWriteE, ResultSrcE0  in  1 each  Execute writes rd; Execute is a load.
- LongIssueE  in  1  Execute holds a valid long op this cycle, dispatched at the edge.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- LongDoneW  in  1  a long-op result is written back this cycle.
- LongRdW  in  5  register written by that long op.
- StallF, StallD  out  1 each  hold the PC and the IF/ID register.
- FlushD, FlushE  out  1 each  clear the IF/ID and ID/EX registers.
- Pending  out  32  scoreboard, one bit per register; bit 0 is always 0.
- SbErr  out  1  sticky protocol-error flag.
- StallCnt  out  CNT_W  count of stall cycles; wraps.

## Operation
- lwStall = ResultSrcE0 & RegWriteE & (rdE≠0) & (rdE==rs1D | rdE==rs2D).
- sbStall = Pending[rs1D] | Pending[rs2D] | (RegWriteD & Pending[rdD]). The rdD term stops a WAW overtake.
- stStall = LongD & (outstanding + LongIssueE ≥ MAX_LONG).
- stall = (lwStall | sbStall | stStall) & ~PCSrcE. A redirect wins because the Decode instruction is discarded anyway.
- StallF = StallD = stall.
- FlushD = PCSrcE.
- FlushE = PCSrcE | stall.
- Scoreboard update at each edge:
  - On LongIssueE with rdE≠0, set Pending[rdE].
  - On LongDoneW, clear Pending[LongRdW].
  - If both hit the same register, set wins: the issue is the newer writer.
  - LongIssueE is never gated by PCSrcE, because the Execute instruction is the older one and stays valid.
- Outstanding counter, 3 bits:
  - +1 on LongIssueE, −1 on LongDoneW.
  - Unchanged when both occur in the same cycle.
- SbErr is set, and stays set until reset, on any of:
  - LongDoneW while the counter is 0. The counter holds at 0.
  - LongDoneW with LongRdW≠0 whose Pending bit is clear.
  - LongIssueE while the counter is at MAX_LONG. The counter holds.
- StallCnt increments on every cycle in which stall=1 and wraps modulo 2^CNT_W.

## Timing
- All stall and flush outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- While rst is low, every output is 0: StallF, StallD, FlushD, FlushE, Pending, SbErr and StallCnt.
- Asserting reset mid-operation discards all in-flight tracking. The pipeline registers are reset at the same time.
- A scoreboard set is visible on Pending and sbStall from the cycle after the issue edge.
  - A dependent instruction that sits in Decode during the issue cycle is already covered by the forwarding path or by lwStall. It is not the scoreboard's responsibility.
- A scoreboard clear is visible the cycle after the LongDoneW edge.
  - While LongDoneW is high, the register file writes the value. A dependent instruction in Decode in that cycle still stalls one cycle. This conservative extra cycle is a decided behaviour.
- A load-use stall lasts exactly one cycle: the load moves to M, and forwarding takes over.

## Structure
- Shared pipeline package holds:
  - register-index width (5) and NREG (32);
  - the long-op counter width;
  - the FORWARD_* encodings, already used by the forwarding unit.
- One natural sub-module: long_scoreboard. It holds Pending, the outstanding counter and SbErr, and exposes the Pending vector plus a count-at-limit signal.
- The top level holds the combinational stall and flush logic and StallCnt.

## Test plan
- Load-use: load x5 in E, rs1D=5 → StallF=StallD=FlushE=1 for one cycle. Next cycle (load in M) → all 0; StallCnt=1.
- Branch during load-use: same stimulus plus PCSrcE=1 → StallF=StallD=0, FlushD=FlushE=1, StallCnt unchanged.
- Long-op dependency: issue DIV to x7 (LongIssueE, rdE=7); Decode reads x7 → stall while Pending[7]=1. After LongDoneW with LongRdW=7 → stall drops one cycle later.
- Same-register set/clear: LongDoneW for x3 in the same cycle as a new issue to x3 → Pending[3] stays 1, counter unchanged, SbErr=0.
- Structural limit (MAX_LONG=2): two long ops outstanding, LongD=1 → stall. After one LongDoneW → stall releases.
- Protocol error and reset: LongDoneW with counter 0 → SbErr=1 and stays set. Asserting rst mid-stall → all outputs 0 asynchronously, Pending=0.
